// File: rtl/cordic_pkg.sv
// Constants and types shared by the CORDIC units (vectoring and sin/cos).
// Angles are 8-bit with 256 = 90 deg; magnitudes carry the CORDIC gain.
package cordic_pkg;

    localparam int N_ITER = 8;
    localparam int IN_W   = 8;
    localparam int INT_W  = 11;
    localparam int Z_W    = 10;
    localparam int ANG_W  = 8;
    localparam int MAG_W  = 10;
    localparam int ITER_W = $clog2(N_ITER);

    // Index 0 is the LSB entry, so ATAN_TABLE[0] = 128 (45 deg).
    localparam logic [N_ITER-1:0][7:0] ATAN_TABLE =
        {8'd1, 8'd3, 8'd5, 8'd10, 8'd20, 8'd40, 8'd76, 8'd128};

    localparam int  GAIN_INV_Q8 = 155;
    localparam real CORDIC_GAIN = 1.6468;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } cordic_state_t;

endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring-mode micro-rotation: drives y toward zero, accumulating the angle in z.
module cordic_vec_step
    import cordic_pkg::*;
(
    input  logic signed [INT_W-1:0]  i_x,
    input  logic signed [INT_W-1:0]  i_y,
    input  logic signed [Z_W-1:0]    i_z,
    input  logic        [ITER_W-1:0] i_iter,
    output logic signed [INT_W-1:0]  o_x,
    output logic signed [INT_W-1:0]  o_y,
    output logic signed [Z_W-1:0]    o_z
);

    logic signed [INT_W-1:0] w_x_sh;
    logic signed [INT_W-1:0] w_y_sh;
    logic signed [Z_W-1:0]   w_atan;
    logic                    w_dir;

    assign w_x_sh = i_x >>> i_iter;
    assign w_y_sh = i_y >>> i_iter;
    assign w_atan = signed'({{(Z_W-8){1'b0}}, ATAN_TABLE[i_iter]});
    // y == 0 rotates clockwise, same as positive y.
    assign w_dir  = ~i_y[INT_W-1];

    assign o_x = w_dir ? (i_x + w_y_sh) : (i_x - w_y_sh);
    assign o_y = w_dir ? (i_y - w_x_sh) : (i_y + w_x_sh);
    assign o_z = w_dir ? (i_z + w_atan) : (i_z - w_atan);

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: first-quadrant (X, Y) -> angle and gain-scaled magnitude.
// state | meaning
// IDLE  | waiting for i_start; operands captured on the accepting edge
// LOAD  | x/y/z/iteration registers initialised from captured operands
// RUN   | one micro-rotation per clock, N_ITER clocks
// DONE  | outputs updated, o_done pulses on the following cycle
module cordic_vectoring
    import cordic_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [IN_W-1:0]  i_x_in,
    input  logic [IN_W-1:0]  i_y_in,
    output logic [ANG_W-1:0] o_angle,
    output logic [MAG_W-1:0] o_mag,
    output logic             o_busy,
    output logic             o_done
);

    cordic_state_t           r_state;
    cordic_state_t           w_state_nxt;

    logic [IN_W-1:0]         r_x_cap;
    logic [IN_W-1:0]         r_y_cap;
    logic signed [INT_W-1:0] r_x;
    logic signed [INT_W-1:0] r_y;
    logic signed [Z_W-1:0]   r_z;
    logic [ITER_W-1:0]       r_iter;
    logic                    r_zero;
    logic [ANG_W-1:0]        r_angle;
    logic [MAG_W-1:0]        r_mag;
    logic                    r_done;

    logic signed [INT_W-1:0] w_x_nxt;
    logic signed [INT_W-1:0] w_y_nxt;
    logic signed [Z_W-1:0]   w_z_nxt;
    logic                    w_last_iter;
    logic [ANG_W-1:0]        w_angle;
    logic [MAG_W-1:0]        w_mag;

    cordic_vec_step u_step (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_z    (r_z),
        .i_iter (r_iter),
        .o_x    (w_x_nxt),
        .o_y    (w_y_nxt),
        .o_z    (w_z_nxt)
    );

    assign w_last_iter = (r_iter == ITER_W'(N_ITER - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = RUN;
            RUN:     if (w_last_iter) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Saturate z into 0..255: negative clamps low, anything with bits above ANG_W clamps high.
    always_comb begin
        w_angle = r_z[ANG_W-1:0];
        w_mag   = r_x[MAG_W-1:0];
        if (r_zero || r_z[Z_W-1]) begin
            w_angle = '0;
        end else if (r_z[Z_W-2:ANG_W] != '0) begin
            w_angle = '1;
        end
        if (r_zero) begin
            w_mag = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x_cap <= '0;
            r_y_cap <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_zero  <= 1'b0;
            r_angle <= '0;
            r_mag   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_x_cap <= i_x_in;
                        r_y_cap <= i_y_in;
                    end
                end
                LOAD: begin
                    r_x    <= signed'({{(INT_W-IN_W){1'b0}}, r_x_cap});
                    r_y    <= signed'({{(INT_W-IN_W){1'b0}}, r_y_cap});
                    r_z    <= '0;
                    r_iter <= '0;
                    r_zero <= (r_x_cap == '0) && (r_y_cap == '0);
                end
                RUN: begin
                    r_x    <= w_x_nxt;
                    r_y    <= w_y_nxt;
                    r_z    <= w_z_nxt;
                    r_iter <= r_iter + 1'b1;
                end
                DONE: begin
                    r_angle <= w_angle;
                    r_mag   <= w_mag;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_angle = r_angle;
    assign o_mag   = r_mag;
    assign o_done  = r_done;
    assign o_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: driver pushes expected results, monitor checks on o_done.
module tb_cordic_vectoring;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] x_in;
    logic [7:0] y_in;
    logic [7:0] angle;
    logic [9:0] mag;
    logic       busy;
    logic       done;

    typedef struct {
        int ang;
        int mag;
        int done_cyc;
        bit ranged;
        int alo;
        int ahi;
        int mlo;
        int mhi;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   busy_run = 0;
    int   last_ang = 0;
    int   last_mag = 0;

    cordic_vectoring dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_x_in  (x_in),
        .i_y_in  (y_in),
        .o_angle (angle),
        .o_mag   (mag),
        .o_busy  (busy),
        .o_done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Vectoring CORDIC evaluated directly from the micro-rotation rules on plain integers.
    function automatic void ref_model(input int xi, input int yi, output int ang, output int m);
        int at[8] = '{128, 76, 40, 20, 10, 5, 3, 1};
        int x, y, z, xn;
        x = xi;
        y = yi;
        z = 0;
        for (int i = 0; i < 8; i++) begin
            if (y >= 0) begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                z  = z + at[i];
            end else begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                z  = z - at[i];
            end
            x = xn;
        end
        ang = (z < 0) ? 0 : ((z > 255) ? 255 : z);
        m   = x & 1023;
        if (xi == 0 && yi == 0) begin
            ang = 0;
            m   = 0;
        end
    endfunction

    task automatic push_exp(input int x, input int y, input int dcyc, input bit r,
                            input int alo, input int ahi, input int mlo, input int mhi);
        exp_t e;
        ref_model(x, y, e.ang, e.mag);
        e.done_cyc = dcyc;
        e.ranged   = r;
        e.alo = alo; e.ahi = ahi; e.mlo = mlo; e.mhi = mhi;
        last_ang = e.ang;
        last_mag = e.mag;
        sb.push_back(e);
    endtask

    // Called on a negedge; the next posedge is the accepting edge.
    task automatic issue(input int x, input int y, input bit r,
                         input int alo, input int ahi, input int mlo, input int mhi);
        x_in  = 8'(x);
        y_in  = 8'(y);
        start = 1'b1;
        push_exp(x, y, cyc + 11, r, alo, ahi, mlo, mhi);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int b = 0;
        while (sb.size() != 0 && b < 40) begin
            @(negedge clk);
            b++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, expected no result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("angle", int'(angle), e.ang);
                chk("mag", int'(mag), e.mag);
                chk("latency", cyc, e.done_cyc);
                chk("busy_cycles", busy_run, 10);
                if (e.ranged) begin
                    chk_rng("angle_accuracy", int'(angle), e.alo, e.ahi);
                    chk_rng("mag_accuracy", int'(mag), e.mlo, e.mhi);
                end
            end
            busy_run = 0;
        end else if (!busy) begin
            busy_run = 0;
        end else begin
            busy_run++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        rst_n = 1'b0;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (3) @(negedge clk);
        chk("rst_angle", int'(angle), 0);
        chk("rst_mag", int'(mag), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(200, 0,   1, 0,   3,   323, 335); wait_idle();
        issue(100, 100, 1, 125, 131, 229, 237); wait_idle();
        issue(0,   150, 1, 253, 255, 242, 252); wait_idle();
        issue(0,   0,   1, 0,   0,   0,   0);   wait_idle();
        issue(255, 255, 1, 125, 131, 585, 603); wait_idle();

        // START pulses during a run must be ignored.
        issue(60, 200, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        x_in = 8'd17; y_in = 8'd230; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        x_in = 8'd250; y_in = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (15) @(negedge clk);

        // Reset during RUN iteration 4: immediate clear, no result.
        issue(150, 60, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_angle", int'(angle), 0);
        chk("midrst_mag", int'(mag), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        issue(100, 100, 1, 125, 131, 229, 237); wait_idle();

        // START held high: a result every 11 cycles.
        n0 = cyc;
        x_in = 8'd37; y_in = 8'd181; start = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(37, 181, n0 + 11 + 11 * k, 0, 0, 0, 0, 0);
        repeat (33) @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (13) @(negedge clk);

        for (int v = 0; v < 150; v++) begin
            int rx, ry, gap;
            rx  = int'($urandom_range(255, 0));
            ry  = int'($urandom_range(255, 0));
            gap = int'($urandom_range(3, 0));
            if (v % 25 == 0) ry = 0;
            if (v % 25 == 1) rx = 0;
            issue(rx, ry, 0, 0, 0, 0, 0);
            wait_idle();
            repeat (gap) @(negedge clk);
            if (v % 10 == 0) begin
                chk("hold_angle", int'(angle), last_ang);
                chk("hold_mag", int'(mag), last_mag);
            end
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
